// File: rtl/atm_pkg.sv
// Shared definitions for the ATM cash dispenser: denomination codes, note
// values, controller states, error codes and default cassette fill levels.
package atm_pkg;

  typedef enum logic [1:0] {
    DENOM_100  = 2'b00,
    DENOM_500  = 2'b01,
    DENOM_2000 = 2'b10
  } denom_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_PLAN,
    S_DISPENSE,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_AMOUNT = 2'b01;
  localparam logic [1:0] ERR_NOTES  = 2'b10;

  localparam logic [15:0] VAL_100  = 16'd100;
  localparam logic [15:0] VAL_500  = 16'd500;
  localparam logic [15:0] VAL_2000 = 16'd2000;

  localparam int unsigned DEF_N2000_INIT = 50;
  localparam int unsigned DEF_N500_INIT  = 100;
  localparam int unsigned DEF_N100_INIT  = 200;

  function automatic logic [15:0] denom_value(input logic [1:0] d);
    case (d)
      DENOM_2000: denom_value = VAL_2000;
      DENOM_500:  denom_value = VAL_500;
      default:    denom_value = VAL_100;
    endcase
  endfunction

endpackage

// File: rtl/atm_note_planner.sv
// Greedy one-step note selector (combinational).
//   rem_i          : amount still to be planned
//   s2000_i..s100_i: shadow cassette counts
//   denom_o        : largest denomination that fits rem_i and is still stocked
//   valid_o        : a usable denomination exists
module atm_note_planner
  import atm_pkg::*;
(
  input  logic [15:0] rem_i,
  input  logic [7:0]  s2000_i,
  input  logic [7:0]  s500_i,
  input  logic [7:0]  s100_i,
  output logic [1:0]  denom_o,
  output logic        valid_o
);

  always_comb begin
    denom_o = DENOM_100;
    valid_o = 1'b1;
    if (rem_i >= VAL_2000 && s2000_i != '0) begin
      denom_o = DENOM_2000;
    end else if (rem_i >= VAL_500 && s500_i != '0) begin
      denom_o = DENOM_500;
    end else if (rem_i >= VAL_100 && s100_i != '0) begin
      denom_o = DENOM_100;
    end else begin
      valid_o = 1'b0;
    end
  end

endmodule

// File: rtl/atm_cash_dispenser.sv
// ATM cash dispenser controller.
// A rising edge on cash_dis in IDLE latches amount; the amount is validated,
// a greedy note plan is built one note per cycle on shadow counts, and the
// planned notes are then handed out 2000s first, then 500s, then 100s, one
// per note_push & note_ready cycle.
// Ports:
//   clk, reset (async, active low)
//   cash_dis, amount, refill, note_ready : request / control inputs
//   note_push, note_denom                : note handshake to the mechanism
//   busy, done, err, err_code            : status
//   cnt2000, cnt500, cnt100              : live cassette counts
module atm_cash_dispenser
  import atm_pkg::*;
#(
  parameter int unsigned N2000_INIT = DEF_N2000_INIT,
  parameter int unsigned N500_INIT  = DEF_N500_INIT,
  parameter int unsigned N100_INIT  = DEF_N100_INIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cash_dis,
  input  logic [15:0] amount,
  input  logic        refill,
  input  logic        note_ready,
  output logic        note_push,
  output logic [1:0]  note_denom,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [7:0]  cnt2000,
  output logic [7:0]  cnt500,
  output logic [7:0]  cnt100
);

  localparam logic [7:0] INIT2000 = 8'(N2000_INIT);
  localparam logic [7:0] INIT500  = 8'(N500_INIT);
  localparam logic [7:0] INIT100  = 8'(N100_INIT);

  state_e      state_q, state_d;
  logic        cash_dis_q;
  logic [15:0] rem_q, rem_d;
  logic [7:0]  c2000_q, c2000_d, c500_q, c500_d, c100_q, c100_d;
  logic [7:0]  s2000_q, s2000_d, s500_q, s500_d, s100_q, s100_d;
  logic [9:0]  p2000_q, p2000_d, p500_q, p500_d, p100_q, p100_d;
  logic [1:0]  err_code_q, err_code_d;

  logic        req_rise;
  logic [1:0]  plan_denom;
  logic        plan_valid;
  denom_e      denom_sel;
  logic [11:0] notes_left;

  // The edge register tracks cash_dis in every state, so an edge seen while
  // busy is consumed and a level still held high on return to IDLE is not
  // mistaken for a new request.
  assign req_rise   = cash_dis & ~cash_dis_q;
  assign notes_left = 12'(p2000_q) + 12'(p500_q) + 12'(p100_q);

  atm_note_planner u_planner (
    .rem_i   (rem_q),
    .s2000_i (s2000_q),
    .s500_i  (s500_q),
    .s100_i  (s100_q),
    .denom_o (plan_denom),
    .valid_o (plan_valid)
  );

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    c2000_d    = c2000_q;
    c500_d     = c500_q;
    c100_d     = c100_q;
    s2000_d    = s2000_q;
    s500_d     = s500_q;
    s100_d     = s100_q;
    p2000_d    = p2000_q;
    p500_d     = p500_q;
    p100_d     = p100_q;
    err_code_d = err_code_q;
    note_push  = 1'b0;
    denom_sel  = DENOM_100;
    unique case (state_q)
      S_IDLE: begin
        if (refill) begin
          c2000_d = INIT2000;
          c500_d  = INIT500;
          c100_d  = INIT100;
        end
        if (req_rise) begin
          rem_d      = amount;
          err_code_d = ERR_NONE;
          state_d    = S_CHECK;
        end
      end
      S_CHECK: begin
        // Shadows snapshot the counts after any same-cycle refill.
        s2000_d = c2000_q;
        s500_d  = c500_q;
        s100_d  = c100_q;
        p2000_d = '0;
        p500_d  = '0;
        p100_d  = '0;
        if (rem_q == '0 || (rem_q % VAL_100) != '0) begin
          err_code_d = ERR_AMOUNT;
          state_d    = S_ERR;
        end else begin
          state_d = S_PLAN;
        end
      end
      S_PLAN: begin
        if (rem_q == '0) begin
          state_d = S_DISPENSE;
        end else if (!plan_valid) begin
          err_code_d = ERR_NOTES;
          state_d    = S_ERR;
        end else begin
          rem_d = rem_q - denom_value(plan_denom);
          case (plan_denom)
            DENOM_2000: begin
              s2000_d = s2000_q - 8'd1;
              p2000_d = p2000_q + 10'd1;
            end
            DENOM_500: begin
              s500_d = s500_q - 8'd1;
              p500_d = p500_q + 10'd1;
            end
            default: begin
              s100_d = s100_q - 8'd1;
              p100_d = p100_q + 10'd1;
            end
          endcase
        end
      end
      S_DISPENSE: begin
        // DISPENSE is left on the last transfer, so a note is always pending here.
        note_push = 1'b1;
        if (p2000_q != '0)     denom_sel = DENOM_2000;
        else if (p500_q != '0) denom_sel = DENOM_500;
        else                   denom_sel = DENOM_100;
        if (note_ready) begin
          case (denom_sel)
            DENOM_2000: begin
              p2000_d = p2000_q - 10'd1;
              c2000_d = c2000_q - 8'd1;
            end
            DENOM_500: begin
              p500_d = p500_q - 10'd1;
              c500_d = c500_q - 8'd1;
            end
            default: begin
              p100_d = p100_q - 10'd1;
              c100_d = c100_q - 8'd1;
            end
          endcase
          if (notes_left == 12'd1) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cash_dis_q <= 1'b0;
      rem_q      <= '0;
      c2000_q    <= INIT2000;
      c500_q     <= INIT500;
      c100_q     <= INIT100;
      s2000_q    <= '0;
      s500_q     <= '0;
      s100_q     <= '0;
      p2000_q    <= '0;
      p500_q     <= '0;
      p100_q     <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      cash_dis_q <= cash_dis;
      rem_q      <= rem_d;
      c2000_q    <= c2000_d;
      c500_q     <= c500_d;
      c100_q     <= c100_d;
      s2000_q    <= s2000_d;
      s500_q     <= s500_d;
      s100_q     <= s100_d;
      p2000_q    <= p2000_d;
      p500_q     <= p500_d;
      p100_q     <= p100_d;
      err_code_q <= err_code_d;
    end
  end

  assign note_denom = denom_sel;
  assign busy       = (state_q == S_CHECK) || (state_q == S_PLAN) || (state_q == S_DISPENSE);
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_ERR);
  assign err_code   = err_code_q;
  assign cnt2000    = c2000_q;
  assign cnt500     = c500_q;
  assign cnt100     = c100_q;

endmodule

// File: tb/tb_atm_cash_dispenser.sv
// Bench for atm_cash_dispenser: three instances (default fill, a single 2000
// note, only five 100 notes) driven by scenario tasks and compared against a
// greedy arithmetic model of the cassettes.
module tb_atm_cash_dispenser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rst_n      = '0;
  logic [2:0]       cash_dis   = '0;
  logic [2:0][15:0] amount     = '0;
  logic [2:0]       refill     = '0;
  logic [2:0]       note_ready = '0;
  logic [2:0]       note_push, busy, done, err;
  logic [2:0][1:0]  note_denom, err_code;
  logic [2:0][7:0]  cnt2000, cnt500, cnt100;

  int checks = 0;
  int failures = 0;
  // Model counts indexed [instance][0=100, 1=500, 2=2000].
  int m_cnt [3][3];
  int init_cnt [3][3];

  atm_cash_dispenser u_dut0 (
    .clk(clk), .reset(rst_n[0]), .cash_dis(cash_dis[0]), .amount(amount[0]),
    .refill(refill[0]), .note_ready(note_ready[0]), .note_push(note_push[0]),
    .note_denom(note_denom[0]), .busy(busy[0]), .done(done[0]), .err(err[0]),
    .err_code(err_code[0]), .cnt2000(cnt2000[0]), .cnt500(cnt500[0]), .cnt100(cnt100[0]));

  atm_cash_dispenser #(.N2000_INIT(1)) u_dut1 (
    .clk(clk), .reset(rst_n[1]), .cash_dis(cash_dis[1]), .amount(amount[1]),
    .refill(refill[1]), .note_ready(note_ready[1]), .note_push(note_push[1]),
    .note_denom(note_denom[1]), .busy(busy[1]), .done(done[1]), .err(err[1]),
    .err_code(err_code[1]), .cnt2000(cnt2000[1]), .cnt500(cnt500[1]), .cnt100(cnt100[1]));

  atm_cash_dispenser #(.N2000_INIT(0), .N500_INIT(0), .N100_INIT(5)) u_dut2 (
    .clk(clk), .reset(rst_n[2]), .cash_dis(cash_dis[2]), .amount(amount[2]),
    .refill(refill[2]), .note_ready(note_ready[2]), .note_push(note_push[2]),
    .note_denom(note_denom[2]), .busy(busy[2]), .done(done[2]), .err(err[2]),
    .err_code(err_code[2]), .cnt2000(cnt2000[2]), .cnt500(cnt500[2]), .cnt100(cnt100[2]));

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Greedy plan from plain arithmetic: take as many of each note as fit.
  function automatic void model_plan(input int k, input int amt, output int code,
                                     output int e2000, output int e500, output int e100);
    int rem;
    e2000 = 0; e500 = 0; e100 = 0;
    if (amt == 0 || amt % 100 != 0) begin
      code = 1;
      return;
    end
    rem   = amt;
    e2000 = imin(rem / 2000, m_cnt[k][2]); rem -= e2000 * 2000;
    e500  = imin(rem / 500,  m_cnt[k][1]); rem -= e500 * 500;
    e100  = imin(rem / 100,  m_cnt[k][0]); rem -= e100 * 100;
    code  = (rem == 0) ? 0 : 2;
    if (code != 0) begin
      e2000 = 0; e500 = 0; e100 = 0;
    end
  endfunction

  // Drives one request and reports what was observed.
  // mode: 0 ready always 1, 1 random ready, 2 alternating ready.
  // rf:   0 none, 1 refill with the request, 2 refill pulse while busy.
  // outcome: 0 timeout, 1 done, 2 err.  viol counts protocol breaches.
  task automatic run_withdraw(input int k, input int amt, input int mode, input int rf,
                              output int outcome, output int ecode, output int n2000,
                              output int n500, output int n100, output int pushes,
                              output int viol);
    bit       prev_stall, tog;
    logic [1:0] prev_den;
    int       last_rank, rank;
    outcome = 0; ecode = 0; n2000 = 0; n500 = 0; n100 = 0; pushes = 0; viol = 0;
    prev_stall = 0; tog = 0; last_rank = 0; prev_den = 2'b00;
    @(negedge clk);
    amount[k]   = 16'(amt);
    cash_dis[k] = 1'b1;
    refill[k]   = (rf == 1);
    @(negedge clk);
    refill[k] = 1'b0;
    for (int cyc = 0; cyc < 5000 && outcome == 0; cyc++) begin
      case (mode)
        0:       note_ready[k] = 1'b1;
        1:       note_ready[k] = 1'($urandom_range(0, 1));
        default: begin tog = ~tog; note_ready[k] = tog; end
      endcase
      if (rf == 2) refill[k] = (cyc == 1);
      if (note_push[k]) begin
        pushes++;
        if (!busy[k]) viol++;
        if (prev_stall && note_denom[k] != prev_den) viol++;
        if (note_denom[k] == 2'b11) viol++;
        rank = 2 - int'(note_denom[k]);
        if (rank < last_rank) viol++;
        last_rank = rank;
        if (note_ready[k]) begin
          case (note_denom[k])
            2'b10:   n2000++;
            2'b01:   n500++;
            default: n100++;
          endcase
        end
        prev_stall = !note_ready[k];
        prev_den   = note_denom[k];
      end else begin
        if (prev_stall) viol++;
        prev_stall = 0;
      end
      if (done[k]) outcome = 1;
      else if (err[k]) begin
        outcome = 2;
        ecode   = int'(err_code[k]);
      end
      if (outcome == 0) @(negedge clk);
    end
    refill[k] = 1'b0;
    @(negedge clk);
    if (done[k] || err[k] || busy[k] || note_push[k]) viol++;
    if (outcome == 2 && int'(err_code[k]) != ecode) viol++;
    cash_dis[k]   = 1'b0;
    note_ready[k] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = '0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (note_push[k] !== 1'b0 || busy[k] !== 1'b0 || done[k] !== 1'b0 || err[k] !== 1'b0) begin
        failures++;
        $display("FAIL reset_status[%0d]: push=%b busy=%b done=%b err=%b, expected all 0",
                 k, note_push[k], busy[k], done[k], err[k]);
      end
      checks++;
      if (err_code[k] !== 2'b00 || note_denom[k] !== 2'b00) begin
        failures++;
        $display("FAIL reset_codes[%0d]: err_code=%b denom=%b, expected 00/00",
                 k, err_code[k], note_denom[k]);
      end
      checks++;
      if (cnt2000[k] !== 8'(init_cnt[k][2]) || cnt500[k] !== 8'(init_cnt[k][1]) ||
          cnt100[k] !== 8'(init_cnt[k][0])) begin
        failures++;
        $display("FAIL reset_counts[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", k,
                 cnt2000[k], cnt500[k], cnt100[k], init_cnt[k][2], init_cnt[k][1], init_cnt[k][0]);
      end
    end
    rst_n = '1;
    @(negedge clk);
  endtask

  task automatic test_basic_5600();
    int oc, ec, a, b, c, p, v;
    run_withdraw(0, 5600, 0, 0, oc, ec, a, b, c, p, v);
    m_cnt[0][2] -= 2; m_cnt[0][1] -= 3; m_cnt[0][0] -= 1;
    checks++;
    if (oc != 1 || a != 2 || b != 3 || c != 1) begin
      failures++;
      $display("FAIL basic_notes: outcome=%0d notes=%0d/%0d/%0d expected 1 2/3/1", oc, a, b, c);
    end
    checks++;
    if (p != 6 || v != 0) begin
      failures++;
      $display("FAIL basic_consecutive: push_cycles=%0d viol=%0d expected 6/0", p, v);
    end
    checks++;
    if (cnt2000[0] !== 8'd48 || cnt500[0] !== 8'd97 || cnt100[0] !== 8'd199) begin
      failures++;
      $display("FAIL basic_counts: got %0d/%0d/%0d expected 48/97/199",
               cnt2000[0], cnt500[0], cnt100[0]);
    end
  endtask

  task automatic test_bad_amount();
    int oc, ec, a, b, c, p, v;
    int amts [2] = '{250, 0};
    for (int i = 0; i < 2; i++) begin
      run_withdraw(0, amts[i], 0, 0, oc, ec, a, b, c, p, v);
      checks++;
      if (oc != 2 || ec != 1 || p != 0 || v != 0) begin
        failures++;
        $display("FAIL bad_amount_%0d: outcome=%0d code=%0d pushes=%0d viol=%0d expected 2/1/0/0",
                 amts[i], oc, ec, p, v);
      end
      checks++;
      if (cnt2000[0] !== 8'(m_cnt[0][2]) || cnt500[0] !== 8'(m_cnt[0][1]) ||
          cnt100[0] !== 8'(m_cnt[0][0])) begin
        failures++;
        $display("FAIL bad_amount_counts_%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", amts[i],
                 cnt2000[0], cnt500[0], cnt100[0], m_cnt[0][2], m_cnt[0][1], m_cnt[0][0]);
      end
    end
  endtask

  task automatic test_limited_2000();
    int oc, ec, a, b, c, p, v;
    run_withdraw(1, 4000, 0, 0, oc, ec, a, b, c, p, v);
    checks++;
    if (oc != 1 || a != 1 || b != 4 || c != 0 || v != 0) begin
      failures++;
      $display("FAIL limited_notes: outcome=%0d notes=%0d/%0d/%0d viol=%0d expected 1 1/4/0 0",
               oc, a, b, c, v);
    end
    checks++;
    if (cnt2000[1] !== 8'd0 || cnt500[1] !== 8'd96 || cnt100[1] !== 8'd200) begin
      failures++;
      $display("FAIL limited_counts: got %0d/%0d/%0d expected 0/96/200",
               cnt2000[1], cnt500[1], cnt100[1]);
    end
  endtask

  task automatic test_insufficient();
    int oc, ec, a, b, c, p, v;
    run_withdraw(2, 600, 0, 0, oc, ec, a, b, c, p, v);
    checks++;
    if (oc != 2 || ec != 2 || p != 0 || v != 0) begin
      failures++;
      $display("FAIL insufficient: outcome=%0d code=%0d pushes=%0d viol=%0d expected 2/2/0/0",
               oc, ec, p, v);
    end
    checks++;
    if (cnt100[2] !== 8'd5 || cnt500[2] !== 8'd0 || cnt2000[2] !== 8'd0) begin
      failures++;
      $display("FAIL insufficient_counts: got %0d/%0d/%0d expected 0/0/5",
               cnt2000[2], cnt500[2], cnt100[2]);
    end
  endtask

  task automatic test_stall();
    int oc, ec, a, b, c, p, v;
    run_withdraw(0, 2500, 2, 0, oc, ec, a, b, c, p, v);
    m_cnt[0][2] -= 1; m_cnt[0][1] -= 1;
    checks++;
    if (oc != 1 || a != 1 || b != 1 || c != 0) begin
      failures++;
      $display("FAIL stall_notes: outcome=%0d notes=%0d/%0d/%0d expected 1 1/1/0", oc, a, b, c);
    end
    checks++;
    if (v != 0 || p < 3) begin
      failures++;
      $display("FAIL stall_hold: viol=%0d push_cycles=%0d expected 0 and >=3", v, p);
    end
  endtask

  task automatic test_refill();
    int oc, ec, a, b, c, p, v, mc, e2, e5, e1;
    // Refill alongside the request: the plan sees the refilled cassettes.
    for (int i = 0; i < 3; i++) m_cnt[0][i] = init_cnt[0][i];
    model_plan(0, 3300, mc, e2, e5, e1);
    run_withdraw(0, 3300, 0, 1, oc, ec, a, b, c, p, v);
    m_cnt[0][2] -= e2; m_cnt[0][1] -= e5; m_cnt[0][0] -= e1;
    checks++;
    if (oc != 1 || a != e2 || b != e5 || c != e1 || v != 0) begin
      failures++;
      $display("FAIL refill_with_req: outcome=%0d notes=%0d/%0d/%0d viol=%0d expected 1 %0d/%0d/%0d 0",
               oc, a, b, c, v, e2, e5, e1);
    end
    checks++;
    if (cnt2000[0] !== 8'(m_cnt[0][2]) || cnt500[0] !== 8'(m_cnt[0][1]) ||
        cnt100[0] !== 8'(m_cnt[0][0])) begin
      failures++;
      $display("FAIL refill_with_req_counts: got %0d/%0d/%0d expected %0d/%0d/%0d",
               cnt2000[0], cnt500[0], cnt100[0], m_cnt[0][2], m_cnt[0][1], m_cnt[0][0]);
    end
    // Refill while busy is ignored.
    model_plan(0, 700, mc, e2, e5, e1);
    run_withdraw(0, 700, 1, 2, oc, ec, a, b, c, p, v);
    m_cnt[0][2] -= e2; m_cnt[0][1] -= e5; m_cnt[0][0] -= e1;
    checks++;
    if (cnt2000[0] !== 8'(m_cnt[0][2]) || cnt500[0] !== 8'(m_cnt[0][1]) ||
        cnt100[0] !== 8'(m_cnt[0][0]) || oc != 1) begin
      failures++;
      $display("FAIL refill_busy_ignored: got %0d/%0d/%0d oc=%0d expected %0d/%0d/%0d oc=1",
               cnt2000[0], cnt500[0], cnt100[0], oc, m_cnt[0][2], m_cnt[0][1], m_cnt[0][0]);
    end
  endtask

  task automatic test_reset_mid();
    int seen, oc, ec, a, b, c, p, v;
    bit hit;
    seen = 0; hit = 0;
    @(negedge clk);
    amount[0] = 16'd5600; cash_dis[0] = 1'b1; note_ready[0] = 1'b1;
    for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
      @(negedge clk);
      if (note_push[0]) begin
        seen++;
        if (seen == 2) hit = 1;
      end
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL reset_mid_reach: push cycles seen=%0d expected 2", seen);
    end
    rst_n[0] = 1'b0;
    #1;
    checks++;
    if (note_push[0] !== 1'b0 || busy[0] !== 1'b0 || done[0] !== 1'b0 || err[0] !== 1'b0 ||
        err_code[0] !== 2'b00 || note_denom[0] !== 2'b00) begin
      failures++;
      $display("FAIL reset_mid_outputs: push=%b busy=%b done=%b err=%b code=%b denom=%b expected zeros",
               note_push[0], busy[0], done[0], err[0], err_code[0], note_denom[0]);
    end
    checks++;
    if (cnt2000[0] !== 8'd50 || cnt500[0] !== 8'd100 || cnt100[0] !== 8'd200) begin
      failures++;
      $display("FAIL reset_mid_counts: got %0d/%0d/%0d expected 50/100/200",
               cnt2000[0], cnt500[0], cnt100[0]);
    end
    cash_dis[0] = 1'b0; note_ready[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b1;
    for (int i = 0; i < 3; i++) m_cnt[0][i] = init_cnt[0][i];
    @(negedge clk);
    run_withdraw(0, 5600, 0, 0, oc, ec, a, b, c, p, v);
    m_cnt[0][2] -= 2; m_cnt[0][1] -= 3; m_cnt[0][0] -= 1;
    checks++;
    if (oc != 1 || cnt2000[0] !== 8'd48 || cnt500[0] !== 8'd97 || cnt100[0] !== 8'd199) begin
      failures++;
      $display("FAIL reset_mid_next_req: oc=%0d counts %0d/%0d/%0d expected 1 48/97/199",
               oc, cnt2000[0], cnt500[0], cnt100[0]);
    end
  endtask

  task automatic test_random();
    int oc, ec, a, b, c, p, v, mc, e2, e5, e1, amt, sel, mode, rf;
    for (int it = 0; it < 30; it++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      amt = int'($urandom_range(1, 65535));
      else if (sel == 1) amt = 0;
      else if (sel == 2) amt = 65500;
      else               amt = 100 * int'($urandom_range(1, 120));
      mode = int'($urandom_range(0, 1));
      rf   = ($urandom_range(0, 9) == 0) ? 1 : 0;
      if (rf == 1) for (int i = 0; i < 3; i++) m_cnt[0][i] = init_cnt[0][i];
      model_plan(0, amt, mc, e2, e5, e1);
      run_withdraw(0, amt, mode, rf, oc, ec, a, b, c, p, v);
      m_cnt[0][2] -= e2; m_cnt[0][1] -= e5; m_cnt[0][0] -= e1;
      checks++;
      if (oc != ((mc == 0) ? 1 : 2) || (mc != 0 && ec != mc)) begin
        failures++;
        $display("FAIL rand_outcome it=%0d amt=%0d: outcome=%0d code=%0d expected code %0d",
                 it, amt, oc, ec, mc);
      end
      checks++;
      if (a != e2 || b != e5 || c != e1 || v != 0) begin
        failures++;
        $display("FAIL rand_notes it=%0d amt=%0d: notes=%0d/%0d/%0d viol=%0d expected %0d/%0d/%0d 0",
                 it, amt, a, b, c, v, e2, e5, e1);
      end
      checks++;
      if (cnt2000[0] !== 8'(m_cnt[0][2]) || cnt500[0] !== 8'(m_cnt[0][1]) ||
          cnt100[0] !== 8'(m_cnt[0][0])) begin
        failures++;
        $display("FAIL rand_counts it=%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", it,
                 cnt2000[0], cnt500[0], cnt100[0], m_cnt[0][2], m_cnt[0][1], m_cnt[0][0]);
      end
    end
  endtask

  initial begin
    init_cnt[0] = '{200, 100, 50};
    init_cnt[1] = '{200, 100, 1};
    init_cnt[2] = '{5, 0, 0};
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 3; i++) m_cnt[k][i] = init_cnt[k][i];
    test_reset();
    test_basic_5600();
    test_bad_amount();
    test_limited_2000();
    test_insufficient();
    test_stall();
    test_refill();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
